// File: rtl/id_buf_stage_pkg.sv
// Shared decode constants, FSM state encoding and EX bundle type for the
// id_buf_stage decode slice.
package id_buf_stage_pkg;

    localparam int INST_W     = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [INST_W-1:0]     ZERO_WORD = '0;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG  = '0;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD   = 3'b000;
    localparam logic [2:0] F3_SLL   = 3'b001;
    localparam logic [2:0] F3_SW    = 3'b010;
    localparam logic [2:0] F3_SR    = 3'b101;
    localparam logic [2:0] F3_JALR  = 3'b000;
    localparam logic [2:0] F3_FENCE = 3'b000;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    typedef enum logic {
        ST_RUN        = 1'b0,
        ST_FENCE_WAIT = 1'b1
    } fsm_state_e;

    typedef struct packed {
        logic [31:0]           op1;
        logic [31:0]           op2;
        logic [31:0]           op1_jump;
        logic [31:0]           op2_jump;
        logic [31:0]           reg1_rdata;
        logic [31:0]           reg2_rdata;
        logic                  reg_we;
        logic [REG_ADDR_W-1:0] reg_waddr;
        logic                  illegal;
    } id_bundle_t;

endpackage

// File: rtl/id_decode_comb.sv
// Purely combinational RV32I decode of one instruction into an EX bundle.
// Macro ID_RV32M_EN adds the RV32M funct7=0x01 group; otherwise it is illegal.
module id_decode_comb
    import id_buf_stage_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [INST_W-1:0]     inst_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [31:0]           reg1_rdata_i,
    input  logic [31:0]           reg2_rdata_i,
    output logic [REG_ADDR_W-1:0] reg1_raddr_o,
    output logic [REG_ADDR_W-1:0] reg2_raddr_o,
    output logic                  is_fence_o,
    output id_bundle_t            bundle_o
);

    logic [6:0]            opcode;
    logic [6:0]            funct7;
    logic [2:0]            funct3;
    logic [REG_ADDR_W-1:0] rd, rs1, rs2;
    logic [31:0]           pc, imm_i, imm_s, imm_b, imm_j, imm_u;
    logic                  legal, use_rs1, use_rs2, writes_rd;

    assign opcode = inst_i[6:0];
    assign rd     = inst_i[11:7];
    assign funct3 = inst_i[14:12];
    assign rs1    = inst_i[19:15];
    assign rs2    = inst_i[24:20];
    assign funct7 = inst_i[31:25];

    assign pc    = 32'(addr_i);
    assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
    assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
    assign imm_u = {inst_i[31:12], 12'b0};

    // Legality and port usage depend only on the instruction word, which keeps
    // the read-address path free of any loop through the regfile data.
    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        legal      = 1'b0;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        writes_rd  = 1'b0;
        is_fence_o = 1'b0;
        case (opcode)
            OP_IMM: begin
                use_rs1   = 1'b1;
                writes_rd = 1'b1;
                if (funct3 == F3_SLL)     legal = (funct7 == F7_BASE);
                else if (funct3 == F3_SR) legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                else                      legal = 1'b1;
            end
            OP_LOAD: begin
                use_rs1   = 1'b1;
                writes_rd = 1'b1;
                legal     = (funct3 != 3'b011) && (funct3[2:1] != 2'b11);
            end
            OP_REG: begin
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                writes_rd = 1'b1;
                case (funct7)
                    F7_BASE:   legal = 1'b1;
                    F7_ALT:    legal = (funct3 == F3_ADD) || (funct3 == F3_SR);
`ifdef ID_RV32M_EN
                    F7_MULDIV: legal = 1'b1;
`endif
                    default:   legal = 1'b0;
                endcase
            end
            OP_STORE: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                legal   = (funct3 <= F3_SW);
            end
            OP_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                legal   = (funct3[2:1] != 2'b01);
            end
            OP_JAL: begin
                writes_rd = 1'b1;
                legal     = 1'b1;
            end
            OP_JALR: begin
                use_rs1   = 1'b1;
                writes_rd = 1'b1;
                legal     = (funct3 == F3_JALR);
            end
            OP_LUI, OP_AUIPC: begin
                writes_rd = 1'b1;
                legal     = 1'b1;
            end
            OP_FENCE: begin
                legal      = (funct3 == F3_FENCE);
                is_fence_o = legal;
            end
            default: ;
        endcase
        if (!legal) begin
            use_rs1   = 1'b0;
            use_rs2   = 1'b0;
            writes_rd = 1'b0;
        end
    end

    assign reg1_raddr_o = use_rs1 ? rs1 : ZERO_REG;
    assign reg2_raddr_o = use_rs2 ? rs2 : ZERO_REG;

    always_comb begin
        bundle_o = '0;
        case (opcode)
            OP_IMM, OP_LOAD: begin
                bundle_o.op1 = reg1_rdata_i;
                bundle_o.op2 = imm_i;
            end
            OP_REG: begin
                bundle_o.op1 = reg1_rdata_i;
                bundle_o.op2 = reg2_rdata_i;
`ifdef ID_RV32M_EN
                // DIV/DIVU/REM/REMU carry pc+4 as the restart vector for multi-cycle EX.
                if (funct7 == F7_MULDIV && funct3[2]) begin
                    bundle_o.op1_jump = pc;
                    bundle_o.op2_jump = 32'd4;
                end
`endif
            end
            OP_STORE: begin
                bundle_o.op1 = reg1_rdata_i;
                bundle_o.op2 = imm_s;
            end
            OP_BRANCH: begin
                bundle_o.op1      = reg1_rdata_i;
                bundle_o.op2      = reg2_rdata_i;
                bundle_o.op1_jump = pc;
                bundle_o.op2_jump = imm_b;
            end
            OP_JAL: begin
                bundle_o.op1      = pc;
                bundle_o.op2      = 32'd4;
                bundle_o.op1_jump = pc;
                bundle_o.op2_jump = imm_j;
            end
            OP_JALR: begin
                bundle_o.op1      = pc;
                bundle_o.op2      = 32'd4;
                bundle_o.op1_jump = reg1_rdata_i;
                bundle_o.op2_jump = imm_i;
            end
            OP_LUI:   bundle_o.op1 = imm_u;
            OP_AUIPC: begin
                bundle_o.op1 = pc;
                bundle_o.op2 = imm_u;
            end
            OP_FENCE: begin
                bundle_o.op1_jump = pc;
                bundle_o.op2_jump = 32'd4;
            end
            default: ;
        endcase
        bundle_o.reg1_rdata = use_rs1 ? reg1_rdata_i : ZERO_WORD;
        bundle_o.reg2_rdata = use_rs2 ? reg2_rdata_i : ZERO_WORD;
        bundle_o.reg_we     = writes_rd && (rd != ZERO_REG);
        bundle_o.reg_waddr  = writes_rd ? rd : ZERO_REG;
        if (!legal) begin
            bundle_o         = '0;
            bundle_o.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/id_buf_stage.sv
// Buffered decode stage: DEPTH-entry fetch FIFO, FENCE serialisation FSM and a
// registered EX-side bundle. RV32M decode is enabled by defining ID_RV32M_EN.
module id_buf_stage
    import id_buf_stage_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush_i,
    input  logic                    if_valid_i,
    output logic                    if_ready_o,
    input  logic [INST_W-1:0]       if_inst_i,
    input  logic [ADDR_W-1:0]       if_addr_i,
    output logic [REG_ADDR_W-1:0]   reg1_raddr_o,
    output logic [REG_ADDR_W-1:0]   reg2_raddr_o,
    input  logic [31:0]             reg1_rdata_i,
    input  logic [31:0]             reg2_rdata_i,
    output logic                    ex_valid_o,
    input  logic                    ex_ready_i,
    input  logic                    ex_idle_i,
    output logic [INST_W-1:0]       ex_inst_o,
    output logic [ADDR_W-1:0]       ex_inst_addr_o,
    output logic [31:0]             ex_op1_o,
    output logic [31:0]             ex_op2_o,
    output logic [31:0]             ex_op1_jump_o,
    output logic [31:0]             ex_op2_jump_o,
    output logic [31:0]             ex_reg1_rdata_o,
    output logic [31:0]             ex_reg2_rdata_o,
    output logic                    ex_reg_we_o,
    output logic [REG_ADDR_W-1:0]   ex_reg_waddr_o,
    output logic                    ex_illegal_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [INST_W-1:0] inst_mem_q [DEPTH];
    logic [ADDR_W-1:0] addr_mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    fsm_state_e        state_q, state_d;
    logic              ex_valid_q, ex_valid_d;
    logic [INST_W-1:0] ex_inst_q, ex_inst_d;
    logic [ADDR_W-1:0] ex_addr_q, ex_addr_d;
    id_bundle_t        ex_bundle_q, ex_bundle_d, dec_bundle;

    logic              empty, full, push, launch, fsm_allow, fence_ok, head_is_fence;
    logic [INST_W-1:0] head_inst;
    logic [ADDR_W-1:0] head_addr;

    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                        (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
    assign if_ready_o = !full && !flush_i;
    assign push       = if_valid_i && if_ready_o;
    assign count_o    = wr_ptr_q - rd_ptr_q;

    // An empty FIFO presents an all-zero word so the read ports idle at x0.
    assign head_inst = empty ? ZERO_WORD : inst_mem_q[rd_ptr_q[IDX_W-1:0]];
    assign head_addr = empty ? '0 : addr_mem_q[rd_ptr_q[IDX_W-1:0]];

    id_decode_comb #(.ADDR_W(ADDR_W)) u_decode (
        .inst_i       (head_inst),
        .addr_i       (head_addr),
        .reg1_rdata_i (reg1_rdata_i),
        .reg2_rdata_i (reg2_rdata_i),
        .reg1_raddr_o (reg1_raddr_o),
        .reg2_raddr_o (reg2_raddr_o),
        .is_fence_o   (head_is_fence),
        .bundle_o     (dec_bundle)
    );

    assign fence_ok = ex_idle_i && !ex_valid_q;

    always_comb begin
        state_d   = state_q;
        fsm_allow = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (head_is_fence && !fence_ok) state_d = ST_FENCE_WAIT;
                else                            fsm_allow = 1'b1;
            end
            ST_FENCE_WAIT: begin
                if (fence_ok && !empty) begin
                    fsm_allow = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
        if (flush_i) state_d = ST_RUN;
    end

    assign launch = !empty && (!ex_valid_q || ex_ready_i) && fsm_allow && !flush_i;

    always_comb begin
        wr_ptr_d    = wr_ptr_q + PTR_W'(push);
        rd_ptr_d    = rd_ptr_q + PTR_W'(launch);
        ex_valid_d  = ex_valid_q;
        ex_inst_d   = ex_inst_q;
        ex_addr_d   = ex_addr_q;
        ex_bundle_d = ex_bundle_q;
        if (flush_i) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            ex_valid_d  = 1'b0;
            ex_inst_d   = ZERO_WORD;
            ex_addr_d   = '0;
            ex_bundle_d = '0;
        end else if (launch) begin
            ex_valid_d  = 1'b1;
            ex_inst_d   = head_inst;
            ex_addr_d   = head_addr;
            ex_bundle_d = dec_bundle;
        end else if (ex_ready_i) begin
            ex_valid_d  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            state_q     <= ST_RUN;
            ex_valid_q  <= 1'b0;
            ex_inst_q   <= ZERO_WORD;
            ex_addr_q   <= '0;
            ex_bundle_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            state_q     <= state_d;
            ex_valid_q  <= ex_valid_d;
            ex_inst_q   <= ex_inst_d;
            ex_addr_q   <= ex_addr_d;
            ex_bundle_q <= ex_bundle_d;
        end
    end

    // NOTE: FIFO storage is not reset; an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem_q[wr_ptr_q[IDX_W-1:0]] <= if_inst_i;
            addr_mem_q[wr_ptr_q[IDX_W-1:0]] <= if_addr_i;
        end
    end

    assign ex_valid_o      = ex_valid_q;
    assign ex_inst_o       = ex_inst_q;
    assign ex_inst_addr_o  = ex_addr_q;
    assign ex_op1_o        = ex_bundle_q.op1;
    assign ex_op2_o        = ex_bundle_q.op2;
    assign ex_op1_jump_o   = ex_bundle_q.op1_jump;
    assign ex_op2_jump_o   = ex_bundle_q.op2_jump;
    assign ex_reg1_rdata_o = ex_bundle_q.reg1_rdata;
    assign ex_reg2_rdata_o = ex_bundle_q.reg2_rdata;
    assign ex_reg_we_o     = ex_bundle_q.reg_we;
    assign ex_reg_waddr_o  = ex_bundle_q.reg_waddr;
    assign ex_illegal_o    = ex_bundle_q.illegal;

endmodule

// File: tb/tb_id_buf_stage.sv
// Scoreboard bench for id_buf_stage: directed instructions with hand-computed
// bundles, plus backpressure, FENCE, flush and asynchronous reset checks.
module tb_id_buf_stage;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i = 1'b0;
    logic        if_valid_i = 1'b0;
    logic        if_ready_o;
    logic [31:0] if_inst_i = '0;
    logic [ADDR_W-1:0] if_addr_i = '0;
    logic [4:0]  reg1_raddr_o, reg2_raddr_o;
    logic [31:0] reg1_rdata_i, reg2_rdata_i;
    logic        ex_valid_o;
    logic        ex_ready_i = 1'b1;
    logic        ex_idle_i = 1'b1;
    logic [31:0] ex_inst_o;
    logic [ADDR_W-1:0] ex_inst_addr_o;
    logic [31:0] ex_op1_o, ex_op2_o, ex_op1_jump_o, ex_op2_jump_o;
    logic [31:0] ex_reg1_rdata_o, ex_reg2_rdata_o;
    logic        ex_reg_we_o;
    logic [4:0]  ex_reg_waddr_o;
    logic        ex_illegal_o;
    logic [$clog2(DEPTH):0] count_o;

    always #5 clk = ~clk;

    // Regfile model: x0 reads 0, xN reads 0x1000+N.
    assign reg1_rdata_i = (reg1_raddr_o == 5'd0) ? 32'd0 : 32'h1000 + 32'(reg1_raddr_o);
    assign reg2_rdata_i = (reg2_raddr_o == 5'd0) ? 32'd0 : 32'h1000 + 32'(reg2_raddr_o);

    id_buf_stage #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .if_valid_i(if_valid_i), .if_ready_o(if_ready_o),
        .if_inst_i(if_inst_i), .if_addr_i(if_addr_i),
        .reg1_raddr_o(reg1_raddr_o), .reg2_raddr_o(reg2_raddr_o),
        .reg1_rdata_i(reg1_rdata_i), .reg2_rdata_i(reg2_rdata_i),
        .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i), .ex_idle_i(ex_idle_i),
        .ex_inst_o(ex_inst_o), .ex_inst_addr_o(ex_inst_addr_o),
        .ex_op1_o(ex_op1_o), .ex_op2_o(ex_op2_o),
        .ex_op1_jump_o(ex_op1_jump_o), .ex_op2_jump_o(ex_op2_jump_o),
        .ex_reg1_rdata_o(ex_reg1_rdata_o), .ex_reg2_rdata_o(ex_reg2_rdata_o),
        .ex_reg_we_o(ex_reg_we_o), .ex_reg_waddr_o(ex_reg_waddr_o),
        .ex_illegal_o(ex_illegal_o), .count_o(count_o)
    );

    typedef struct {
        logic [31:0] inst, addr, op1, op2, j1, j2, r1, r2;
        logic        we;
        logic [4:0]  waddr;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic exp_t mk(input logic [31:0] inst, addr, op1, op2, j1, j2, r1, r2,
                                input logic we, input logic [4:0] waddr, input logic ill);
        exp_t e;
        e.inst = inst; e.addr = addr; e.op1 = op1; e.op2 = op2;
        e.j1 = j1; e.j2 = j2; e.r1 = r1; e.r2 = r2;
        e.we = we; e.waddr = waddr; e.ill = ill;
        return e;
    endfunction

    // Monitor: every bundle accepted by EX is compared with the scoreboard head.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && ex_valid_o && ex_ready_i) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_bundle: got inst 0x%08h, expected no bundle", ex_inst_o);
                end else begin
                    e = sb.pop_front();
                    check("inst",     ex_inst_o,       e.inst);
                    check("addr",     ex_inst_addr_o,  e.addr);
                    check("op1",      ex_op1_o,        e.op1);
                    check("op2",      ex_op2_o,        e.op2);
                    check("op1_jump", ex_op1_jump_o,   e.j1);
                    check("op2_jump", ex_op2_jump_o,   e.j2);
                    check("reg1_rd",  ex_reg1_rdata_o, e.r1);
                    check("reg2_rd",  ex_reg2_rdata_o, e.r2);
                    check("reg_we",   32'(ex_reg_we_o),    32'(e.we));
                    check("waddr",    32'(ex_reg_waddr_o), 32'(e.waddr));
                    check("illegal",  32'(ex_illegal_o),   32'(e.ill));
                end
            end
        end
    end

    // Drive one fetch entry; waits (bounded) for if_ready_o. Called at posedge+1.
    task automatic push(input logic [31:0] inst, input logic [31:0] addr);
        bit done = 1'b0;
        if_inst_i = inst; if_addr_i = addr; if_valid_i = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (if_ready_o) begin
                @(posedge clk); #1;
                done = 1'b1;
            end
        end
        if_valid_i = 1'b0;
        if (!done) begin
            n_checks++;
            $display("FAIL push_timeout: inst 0x%08h not accepted, expected acceptance", inst);
        end
    endtask

    task automatic expect_push(input exp_t e);
        sb.push_back(e);
        push(e.inst, e.addr);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && (sb.size() != 0 || ex_valid_o); i++) begin
            @(posedge clk); #1;
        end
        check("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout: bench did not finish, expected completion");
        $fatal(1);
    end

    exp_t vec[$];
    exp_t bp[$];

    initial begin : stim
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ex_valid", 32'(ex_valid_o), 32'd0);
        check("rst_count",    32'(count_o),    32'd0);
        check("rst_if_ready", 32'(if_ready_o), 32'd1);
        check("rst_ex_inst",  ex_inst_o,       32'd0);
        check("rst_ex_op2",   ex_op2_o,        32'd0);
        @(posedge clk); #1;

        // addi x1,x0,5: bundle appears one cycle after the push
        expect_push(mk(32'h00500093, 32'h100, 0, 5, 0, 0, 0, 0, 1'b1, 5'd1, 1'b0));
        @(negedge clk);
        check("lat_count_1",  32'(count_o),    32'd1);
        check("lat_valid_0",  32'(ex_valid_o), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("lat_valid_1",  32'(ex_valid_o), 32'd1);
        @(posedge clk); #1;
        wait_drain();

        // Back-to-back directed decode vectors
        vec.push_back(mk(32'hFFF08113, 32'h104, 32'h1001, 32'hFFFFFFFF, 0, 0, 32'h1001, 0, 1'b1, 5'd2, 1'b0));
        vec.push_back(mk(32'h002081B3, 32'h108, 32'h1001, 32'h1002, 0, 0, 32'h1001, 32'h1002, 1'b1, 5'd3, 1'b0));
        vec.push_back(mk(32'h123452B7, 32'h10C, 32'h12345000, 0, 0, 0, 0, 0, 1'b1, 5'd5, 1'b0));
        vec.push_back(mk(32'h010000EF, 32'h300, 32'h300, 4, 32'h300, 16, 0, 0, 1'b1, 5'd1, 1'b0));
        vec.push_back(mk(32'h0020A223, 32'h304, 32'h1001, 4, 0, 0, 32'h1001, 32'h1002, 1'b0, 5'd0, 1'b0));
        vec.push_back(mk(32'h00208463, 32'h200, 32'h1001, 32'h1002, 32'h200, 8, 32'h1001, 32'h1002, 1'b0, 5'd0, 1'b0));
        vec.push_back(mk(32'hFFFFFFFF, 32'h204, 0, 0, 0, 0, 0, 0, 1'b0, 5'd0, 1'b1));
`ifdef ID_RV32M_EN
        vec.push_back(mk(32'h022081B3, 32'h208, 32'h1001, 32'h1002, 0, 0, 32'h1001, 32'h1002, 1'b1, 5'd3, 1'b0));
        vec.push_back(mk(32'h0220D1B3, 32'h20C, 32'h1001, 32'h1002, 32'h20C, 4, 32'h1001, 32'h1002, 1'b1, 5'd3, 1'b0));
`else
        vec.push_back(mk(32'h022081B3, 32'h208, 0, 0, 0, 0, 0, 0, 1'b0, 5'd0, 1'b1));
        vec.push_back(mk(32'h0220D1B3, 32'h20C, 0, 0, 0, 0, 0, 0, 1'b0, 5'd0, 1'b1));
`endif
        foreach (vec[i]) expect_push(vec[i]);
        wait_drain();

        // Backpressure: first entry sits in the output register, four fill the FIFO
        bp.push_back(mk(32'h00500093, 32'h400, 0, 5, 0, 0, 0, 0, 1'b1, 5'd1, 1'b0));
        bp.push_back(mk(32'h002081B3, 32'h404, 32'h1001, 32'h1002, 0, 0, 32'h1001, 32'h1002, 1'b1, 5'd3, 1'b0));
        bp.push_back(mk(32'h402081B3, 32'h408, 32'h1001, 32'h1002, 0, 0, 32'h1001, 32'h1002, 1'b1, 5'd3, 1'b0));
        bp.push_back(mk(32'h123452B7, 32'h40C, 32'h12345000, 0, 0, 0, 0, 0, 1'b1, 5'd5, 1'b0));
        bp.push_back(mk(32'hFFF08113, 32'h410, 32'h1001, 32'hFFFFFFFF, 0, 0, 32'h1001, 0, 1'b1, 5'd2, 1'b0));
        ex_ready_i = 1'b0;
        foreach (bp[i]) expect_push(bp[i]);
        @(negedge clk);
        check("full_count",    32'(count_o),    32'd4);
        check("full_if_ready", 32'(if_ready_o), 32'd0);
        check("full_ex_valid", 32'(ex_valid_o), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("stall_inst",  ex_inst_o,     32'h00500093);
            check("stall_op2",   ex_op2_o,      32'd5);
            check("stall_count", 32'(count_o),  32'd4);
        end
        @(posedge clk); #1;
        ex_ready_i = 1'b1;
        @(negedge clk);
        check("drain_count_4", 32'(count_o), 32'd4);
        for (int k = 3; k >= 0; k--) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("drain_count", 32'(count_o), 32'(k));
        end
        @(posedge clk); #1;
        wait_drain();

        // FENCE waits for EX idle, then launches with jump base pc and offset 4
        ex_idle_i = 1'b0;
        expect_push(mk(32'h0000000F, 32'h100, 0, 0, 32'h100, 4, 0, 0, 1'b0, 5'd0, 1'b0));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("fence_hold_valid", 32'(ex_valid_o), 32'd0);
            check("fence_hold_count", 32'(count_o),    32'd1);
            @(posedge clk); #1;
        end
        ex_idle_i = 1'b1;
        wait_drain();

        // Flush with full FIFO and a pending bundle, push presented in the same cycle
        ex_ready_i = 1'b0;
        foreach (bp[i]) push(bp[i].inst, bp[i].addr);
        @(negedge clk);
        check("pre_flush_count", 32'(count_o),    32'd4);
        check("pre_flush_valid", 32'(ex_valid_o), 32'd1);
        @(posedge clk); #1;
        flush_i = 1'b1; if_valid_i = 1'b1; if_inst_i = 32'h00500093; if_addr_i = 32'h600;
        @(negedge clk);
        check("flush_if_ready", 32'(if_ready_o), 32'd0);
        @(posedge clk); #1;
        flush_i = 1'b0; if_valid_i = 1'b0;
        @(negedge clk);
        check("flush_count", 32'(count_o),    32'd0);
        check("flush_valid", 32'(ex_valid_o), 32'd0);
        @(posedge clk); #1;
        ex_ready_i = 1'b1;
        expect_push(mk(32'h002081B3, 32'h500, 32'h1001, 32'h1002, 0, 0, 32'h1001, 32'h1002, 1'b1, 5'd3, 1'b0));
        wait_drain();
        check("post_flush_count", 32'(count_o), 32'd0);

        // Asynchronous reset mid-operation
        ex_ready_i = 1'b0;
        push(32'h00500093, 32'h700);
        push(32'h002081B3, 32'h704);
        @(negedge clk);
        check("pre_rst_count", 32'(count_o),    32'd1);
        check("pre_rst_valid", 32'(ex_valid_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(ex_valid_o), 32'd0);
        check("async_rst_count", 32'(count_o),    32'd0);
        check("async_rst_inst",  ex_inst_o,       32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        ex_ready_i = 1'b1;
        @(negedge clk);
        check("post_rst_if_ready", 32'(if_ready_o), 32'd1);
        check("post_rst_valid",    32'(ex_valid_o), 32'd0);
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
